// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor: diff = a - b, one digit per clock,
// least-significant digit first, with start/busy/done handshake.
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrow_out,
  output logic                invalid,
  output logic                busy,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [KW-1:0]   k_q, k_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
  logic            inv_q, inv_d;

  logic            bad;
  logic            last;
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [3:0]      res_dig;
  logic [4:0]      t;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad
          | (a[4*i +: 4] > 4'd9)
          | (b[4*i +: 4] > 4'd9);
    end
  end

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k_q == KW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // 5-bit two's-complement difference; bit 4 set means a borrow is needed.
  assign t = {1'b0, a_dig}
           - {1'b0, b_dig}
           - {4'b0, brw_q};

  assign res_dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  assign last    = (k_q == KW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    k_d     = k_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    inv_d   = inv_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          k_d    = '0;
          brw_d  = 1'b0;
          diff_d = '0;
          if (bad) begin
            inv_d   = 1'b1;
            bout_d  = 1'b0;
            state_d = DONE;
          end else begin
            inv_d   = 1'b0;
            state_d = SUB;
          end
        end
      end
      SUB: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (k_q == KW'(i)) begin
            diff_d[4*i +: 4] = res_dig;
          end
        end
        brw_d = t[4];
        if (last) begin
          bout_d  = t[4];
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      k_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      k_q     <= k_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      inv_q   <= inv_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign invalid    = inv_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Directed bench for bcd_subtractor_seq (DIGITS=4):
// hand-computed differences, latency, handshake and reset behaviour.
module tb_bcd_subtractor_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         invalid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .invalid    (invalid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and returns edges from acceptance to done.
  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        output int lat);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid: got %b expected 0", invalid); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'h4321, 16'h1234, lat);
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, DIGITS); end
    checks++; if (diff !== 16'h3087) begin errors++; $display("FAIL basic_diff: got %h expected 3087", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", borrow_out); end
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL basic_invalid: got %b expected 0", invalid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b expected 1", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    repeat (3) step();
    checks++; if (diff !== 16'h3087) begin errors++; $display("FAIL basic_hold: got %h expected 3087", diff); end
  endtask

  task automatic test_borrow_chain();
    int lat;
    run_op(16'h1000, 16'h0001, lat);
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL chain_latency: got %0d expected %0d", lat, DIGITS); end
    checks++; if (diff !== 16'h0999) begin errors++; $display("FAIL chain_diff: got %h expected 0999", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL chain_borrow: got %b expected 0", borrow_out); end
    step();
    run_op(16'h1234, 16'h1234, lat);
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL equal_diff: got %h expected 0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL equal_borrow: got %b expected 0", borrow_out); end
    step();
  endtask

  task automatic test_negative();
    int lat;
    run_op(16'h0000, 16'h0001, lat);
    checks++; if (diff !== 16'h9999) begin errors++; $display("FAIL neg1_diff: got %h expected 9999", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL neg1_borrow: got %b expected 1", borrow_out); end
    step();
    run_op(16'h0250, 16'h0725, lat);
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL neg2_latency: got %0d expected %0d", lat, DIGITS); end
    checks++; if (diff !== 16'h9525) begin errors++; $display("FAIL neg2_diff: got %h expected 9525", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL neg2_borrow: got %b expected 1", borrow_out); end
    step();
  endtask

  task automatic test_invalid();
    int lat;
    run_op(16'h12A4, 16'h0001, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL inv_latency: got %0d expected 0", lat); end
    checks++; if (invalid !== 1'b1) begin errors++; $display("FAIL inv_flag: got %b expected 1", invalid); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL inv_diff: got %h expected 0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL inv_borrow: got %b expected 0", borrow_out); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL inv_pulse: got %b expected 0", done); end
    run_op(16'h0001, 16'h00F0, lat);
    checks++; if (invalid !== 1'b1) begin errors++; $display("FAIL inv_b_flag: got %b expected 1", invalid); end
    step();
    run_op(16'h0009, 16'h0003, lat);
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL inv_clear: got %b expected 0", invalid); end
    checks++; if (diff !== 16'h0006) begin errors++; $display("FAIL inv_next_diff: got %h expected 0006", diff); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    int pulses;
    int extra;
    logic [W-1:0] d;
    logic bo;
    pulses = 0;
    n      = 0;
    extra  = 0;
    d      = '0;
    bo     = 1'b1;
    @(negedge clk);
    a     = 16'h4321;
    b     = 16'h1234;
    start = 1'b1;
    step();
    while (busy && n < 20) begin
      if (done) begin
        pulses++;
        d  = diff;
        bo = borrow_out;
      end
      a = n[0] ? 16'hFFFF : 16'h8888;
      b = 16'h9999;
      step();
      n++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    checks++; if (d !== 16'h3087) begin errors++; $display("FAIL b2b_diff: got %h expected 3087", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL b2b_borrow: got %b expected 0", bo); end
    checks++; if (n !== DIGITS + 1) begin errors++; $display("FAIL b2b_busy_len: got %0d expected %0d", n, DIGITS + 1); end
    a = 16'h0009;
    b = 16'h0003;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b expected 1", busy); end
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, DIGITS); end
    checks++; if (diff !== 16'h0006) begin errors++; $display("FAIL b2b_second_diff: got %h expected 0006", diff); end
    step();
    repeat (4) begin
      if (busy) extra++;
      step();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_third_op: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    seen = 0;
    @(negedge clk);
    a     = 16'h4321;
    b     = 16'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL rmid_diff: got %h expected 0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL rmid_borrow: got %b expected 0", borrow_out); end
    checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL rmid_invalid: got %b expected 0", invalid); end
    repeat (6) begin
      step();
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses expected 0", seen); end
    run_op(16'h0250, 16'h0725, lat);
    checks++; if (lat !== DIGITS) begin errors++; $display("FAIL rmid_latency: got %0d expected %0d", lat, DIGITS); end
    checks++; if (diff !== 16'h9525) begin errors++; $display("FAIL rmid_diff2: got %h expected 9525", diff); end
    checks++; if (borrow_out !== 1'b1) begin errors++; $display("FAIL rmid_borrow2: got %b expected 1", borrow_out); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_borrow_chain();
    test_negative();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
- Digit-serial multi-digit BCD subtractor computing a - b, where a and b are packed BCD operands.
- Processes one BCD digit per clock, least-significant digit first.
- Uses a start/busy/done handshake.
- Inverse-operation companion to the team's combinational BCD adder; used wherever BCD decrement or difference is needed (counters, timers, display arithmetic).

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD
- diff  output  4*DIGITS  packed BCD result
- borrow_out  output  1  1 when a < b; diff is then the ten's complement (10^DIGITS + a - b)
- invalid  output  1  1 when any operand nibble > 9
- busy  output  1  high in SUB and DONE
- done  output  1  one-cycle pulse; results valid

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs, including mid-operation):
  - state=IDLE.
  - diff=0, borrow_out=0, invalid=0, busy=0, done=0.
  - Internal operand registers, digit counter and borrow flag cleared.
  - An interrupted operation produces no done pulse.
- States: IDLE, SUB, DONE.
- IDLE:
  - busy=0, done=0; diff/borrow_out/invalid hold their last values.
  - On an edge with start=1: latch a and b; clear the digit index k and the borrow flag.
  - If any nibble of a or b > 9: go to DONE with invalid=1, diff=0, borrow_out=0.
  - Otherwise: clear invalid and diff, go to SUB.
- SUB, one digit per edge, for k = 0..DIGITS-1:
  - t = a_k - b_k - borrow, computed at 5-bit signed width.
  - If t < 0: digit = t + 10, borrow ← 1; else digit = t, borrow ← 0.
  - Write digit into diff[4k+3:4k].
  - On the edge that processes k = DIGITS-1: borrow_out ← final borrow; go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - Next edge → IDLE unconditionally; start is ignored during DONE.
- Latency:
  - Start accepted at edge E0 → done high in the cycle after edge E0+DIGITS (valid operands).
  - Invalid operands: done high in the cycle after E0 itself.
  - Throughput: one operation per DIGITS+2 cycles.
- start while busy=1: ignored; operands are not re-latched. Changes on a/b after acceptance have no effect.
- diff is not guaranteed stable during SUB; it is valid when done=1 and held until the next accepted start.
- diff digits are always in the range 0..9 for valid inputs.
- Equal operands: diff=0, borrow_out=0.
- No wrap of the digit index beyond DIGITS-1; the counter is sized clog2(DIGITS) bits, with a minimum of 1.

Test Plan (DIGITS=4):
1. a=0x4321, b=0x1234, pulse start → done exactly 5 cycles after the start edge, diff=0x3087, borrow_out=0, invalid=0.
2. a=0x1000, b=0x0001 → borrow chain across three digits, diff=0x0999, borrow_out=0; then a=0x1234, b=0x1234 → diff=0x0000, borrow_out=0.
3. a=0x0000, b=0x0001 → diff=0x9999, borrow_out=1; a=0x0250, b=0x0725 → diff=0x9525, borrow_out=1.
4. a=0x12A4, b=0x0001 → done in the cycle after the start edge, invalid=1, diff=0, borrow_out=0; a following valid op (0x0009-0x0003) → invalid=0, diff=0x0006.
5. Accept 0x4321-0x1234; hold start=1 and change a/b every cycle while busy → single done pulse, diff=0x3087; exactly one further operation starts, on the first IDLE cycle where start=1.
6. Assert reset two cycles after start acceptance → next cycle state IDLE, all outputs 0, no done pulse; a fresh start then completes normally in 5 cycles.
